// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system bus arbiter and decoder.
// Owner/state encodings, decoder address regions and the timeout read value.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN_M0,
        ST_OWN_M1
    } state_e;

    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] GPIO_BASE = 32'h2000_0000;
    localparam logic [31:0] UART_BASE = 32'h3000_0000;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

    function automatic owner_e own_of(state_e s);
        case (s)
            ST_OWN_M0: own_of = OWN_M0;
            ST_OWN_M1: own_of = OWN_M1;
            default:   own_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// One bus master port: request/address/data towards the slave side,
// read data and ready back. Used for both masters and the shared bus.
interface sys_bus_arbiter_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output req, addr, wdata, wmask, wen,
        input  rdata, ready
    );

    modport slave (
        input  req, addr, wdata, wmask, wen,
        output rdata, ready
    );

endinterface

// File: rtl/bus_wdog.sv
// Bus transfer watchdog: counts stalled owned cycles, forces completion
// at the limit and keeps a sticky error flag.
module bus_wdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic bus_ready,
    input  logic err_clr,
    output logic force_done,
    output logic timeout_err
);

    logic [CNT_W-1:0] tmo_cnt;

    assign force_done = active && !bus_ready &&
                        (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!active || bus_ready || force_done) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // a new timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (force_done) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master bus arbiter: fixed priority to M0 with a starvation guard
// for M1, grant held across slave waits, watchdog-forced completion.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    sys_bus_arbiter_if.slave    m0,
    sys_bus_arbiter_if.slave    m1,
    sys_bus_arbiter_if.master   bus,
    output logic [1:0]          owner,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam logic [3:0] SL = 4'(STARVE_LIMIT);

    state_e     state;
    state_e     state_nxt;
    state_e     pick;
    logic [3:0] starve_cnt;
    logic [3:0] starve_inc;
    logic [3:0] starve_nxt;
    logic       own0;
    logic       own1;
    logic       active;
    logic       force_done;
    logic       done;

    assign own0   = (state == ST_OWN_M0);
    assign own1   = (state == ST_OWN_M1);
    assign active = (own0 && m0.req) || (own1 && m1.req);
    assign done   = active && (bus.ready || force_done);

    bus_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (active),
        .bus_ready   (bus.ready),
        .err_clr     (err_clr),
        .force_done  (force_done),
        .timeout_err (timeout_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= own_of(state_nxt);
            starve_cnt <= starve_nxt;
        end
    end

    // arbitration sees the starve count including this cycle's M0 completion
    always_comb begin
        starve_inc = starve_cnt;
        if (own0 && done && m1.req) begin
            starve_inc = (starve_cnt >= SL) ? SL : starve_cnt + 4'd1;
        end

        pick = ST_IDLE;
        if (m1.req && (!m0.req || starve_inc >= SL)) begin
            pick = ST_OWN_M1;
        end else if (m0.req) begin
            pick = ST_OWN_M0;
        end

        state_nxt = state;
        unique case (state)
            ST_IDLE: state_nxt = pick;
            ST_OWN_M0: begin
                if (!m0.req) state_nxt = ST_IDLE;
                else if (done) state_nxt = pick;
            end
            ST_OWN_M1: begin
                if (!m1.req) state_nxt = ST_IDLE;
                else if (done) state_nxt = pick;
            end
            default: state_nxt = ST_IDLE;
        endcase

        starve_nxt = starve_inc;
        if (!m1.req || state_nxt == ST_OWN_M1) begin
            starve_nxt = '0;
        end
    end

    always_comb begin
        bus.req   = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        bus.wen   = 1'b0;
        m0.ready  = 1'b0;
        m0.rdata  = '0;
        m1.ready  = 1'b0;
        m1.rdata  = '0;
        unique case (1'b1)
            own0: begin
                bus.req   = 1'b1;
                bus.addr  = m0.addr;
                bus.wdata = m0.wdata;
                bus.wmask = m0.wmask;
                bus.wen   = m0.wen;
                m0.ready  = done;
                if (done) m0.rdata = force_done ? TIMEOUT_RDATA : bus.rdata;
            end
            own1: begin
                bus.req   = 1'b1;
                bus.addr  = m1.addr;
                bus.wdata = m1.wdata;
                bus.wmask = m1.wmask;
                bus.wen   = m1.wen;
                m1.ready  = done;
                if (done) m1.rdata = force_done ? TIMEOUT_RDATA : bus.rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomised bench for sys_bus_arbiter against a cycle-level model of
// the grant rules, plus directed starvation, timeout, reset and drop cases.
module tb_sys_bus_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [1:0] owner;
    logic       timeout_err;

    sys_bus_arbiter_if m0_if ();
    sys_bus_arbiter_if m1_if ();
    sys_bus_arbiter_if bus_if ();

    sys_bus_arbiter #(
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .bus         (bus_if),
        .owner       (owner),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    logic        rq [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  wm [2];
    logic        we [2];
    logic        brdy;
    logic [31:0] brd;

    assign m0_if.req   = rq[0];
    assign m0_if.addr  = ad[0];
    assign m0_if.wdata = wd[0];
    assign m0_if.wmask = wm[0];
    assign m0_if.wen   = we[0];
    assign m1_if.req   = rq[1];
    assign m1_if.addr  = ad[1];
    assign m1_if.wdata = wd[1];
    assign m1_if.wmask = wm[1];
    assign m1_if.wen   = we[1];
    assign bus_if.ready = brdy;
    assign bus_if.rdata = brd;

    int errors = 0;
    int checks = 0;

    // model: owner 0 none / 1 M0 / 2 M1, starve count, stall count, error flag
    int mo, ms, mt;
    bit me;

    int p_req [2];
    int p_drop [2];
    int p_rdy, p_clr;
    bit busy [2];

    logic [1:0] own_seen;
    logic       te_seen, r0_seen, r1_seen;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic gen(int i);
        if (busy[i]) begin
            if (int'($urandom_range(0, 99)) < p_drop[i]) begin
                busy[i] = 1'b0;
                rq[i] = 1'b0;
            end
        end else if (int'($urandom_range(0, 99)) < p_req[i]) begin
            busy[i] = 1'b1;
            rq[i] = 1'b1;
            ad[i] = $urandom;
            wd[i] = $urandom;
            wm[i] = 4'($urandom);
            we[i] = 1'($urandom);
        end else begin
            rq[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        mo = 0; ms = 0; mt = 0; me = 1'b0;
        busy[0] = 1'b0; busy[1] = 1'b0;
        rq[0] = 1'b0; rq[1] = 1'b0;
    endtask

    task automatic step();
        bit ro, frc, dn;
        int sv, nxt;
        logic [31:0] ea, ewd, erd0, erd1;
        logic [3:0] ewm;
        logic ewe;
        @(negedge clk);
        gen(0);
        gen(1);
        brdy = int'($urandom_range(0, 99)) < p_rdy;
        brd = $urandom;
        err_clr = int'($urandom_range(0, 99)) < p_clr;
        #2;
        ro = (mo == 1) ? rq[0] : (mo == 2) ? rq[1] : 1'b0;
        frc = ro && !brdy && (mt == TO - 1);
        dn = ro && (brdy || frc);
        ea = (mo == 1) ? ad[0] : (mo == 2) ? ad[1] : 32'h0;
        ewd = (mo == 1) ? wd[0] : (mo == 2) ? wd[1] : 32'h0;
        ewm = (mo == 1) ? wm[0] : (mo == 2) ? wm[1] : 4'h0;
        ewe = (mo == 1) ? we[0] : (mo == 2) ? we[1] : 1'b0;
        erd0 = (dn && mo == 1 && !frc) ? brd : 32'h0;
        erd1 = (dn && mo == 2 && !frc) ? brd : 32'h0;
        chk("owner", 32'(owner), 32'(mo));
        chk("bus_addr", bus_if.addr, ea);
        chk("bus_wdata", bus_if.wdata, ewd);
        chk("bus_wmask", 32'(bus_if.wmask), 32'(ewm));
        chk("bus_wen", 32'(bus_if.wen), 32'(ewe));
        chk("m0_ready", 32'(m0_if.ready), 32'(dn && mo == 1));
        chk("m1_ready", 32'(m1_if.ready), 32'(dn && mo == 2));
        chk("m0_rdata", m0_if.rdata, erd0);
        chk("m1_rdata", m1_if.rdata, erd1);
        chk("timeout_err", 32'(timeout_err), 32'(me));
        own_seen = owner;
        te_seen = timeout_err;
        r0_seen = m0_if.ready;
        r1_seen = m1_if.ready;
        if (dn && mo == 1) busy[0] = 1'b0;
        if (dn && mo == 2) busy[1] = 1'b0;
        me = frc ? 1'b1 : (err_clr ? 1'b0 : me);
        mt = (ro && !dn) ? mt + 1 : 0;
        sv = ms;
        if (mo == 1 && dn && rq[1]) sv = (ms < SL) ? ms + 1 : SL;
        if (mo == 0 || dn) begin
            nxt = (rq[1] && (!rq[0] || sv >= SL)) ? 2 : (rq[0] ? 1 : 0);
        end else if (!ro) begin
            nxt = 0;
        end else begin
            nxt = mo;
        end
        ms = (!rq[1] || nxt == 2) ? 0 : sv;
        mo = nxt;
    endtask

    task automatic knobs(int r0, int r1, int d, int rdy, int clr);
        p_req[0] = r0; p_req[1] = r1;
        p_drop[0] = d; p_drop[1] = d;
        p_rdy = rdy; p_clr = clr;
    endtask

    task automatic drain();
        knobs(0, 0, 0, 100, 0);
        repeat (4) step();
    endtask

    int seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            ad[i] = '0; wd[i] = '0; wm[i] = '0; we[i] = 1'b0;
        end
        brdy = 1'b0;
        brd = '0;
        model_reset();
        knobs(0, 0, 0, 100, 0);

        repeat (2) @(negedge clk);
        #2;
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_bus_addr", bus_if.addr, 32'h0);
        chk("rst_ready", 32'({m0_if.ready, m1_if.ready}), 32'h0);
        chk("rst_err", 32'(timeout_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // both masters always requesting: starvation guard rotation
        knobs(100, 100, 0, 100, 0);
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("starve_seq", 32'(own_seen), 32'(seq[k]));
        end

        // M1 stuck transfer hits the watchdog
        drain();
        knobs(0, 100, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (own_seen == 2'd2) n++;
            if (r1_seen) break;
        end
        chk("tmo_len", 32'(n), 32'(TO));
        step();
        chk("tmo_err_set", 32'(te_seen), 32'h1);
        knobs(0, 0, 0, 100, 100);
        step();
        knobs(0, 0, 0, 100, 0);
        step();
        chk("tmo_err_clr", 32'(te_seen), 32'h0);

        // reset in the middle of a stalled M0 write
        drain();
        knobs(100, 0, 0, 0, 0);
        repeat (3) step();
        chk("pre_rst_own", 32'(owner), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_owner", 32'(owner), 32'h0);
        chk("mid_rst_addr", bus_if.addr, 32'h0);
        chk("mid_rst_wen", 32'(bus_if.wen), 32'h0);
        chk("mid_rst_ready", 32'({m0_if.ready, m1_if.ready}), 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        knobs(100, 0, 0, 100, 0);
        step();
        step();
        chk("fresh_m0", 32'(r0_seen), 32'h1);

        // M1 owner abandons its request while stalled
        drain();
        knobs(0, 100, 0, 0, 0);
        step();
        step();
        chk("m1_owned", 32'(own_seen), 32'h2);
        knobs(100, 0, 0, 0, 0);
        p_drop[1] = 100;
        step();
        chk("drop_no_ready", 32'(r1_seen), 32'h0);
        p_drop[1] = 0;
        step();
        chk("drop_idle", 32'(own_seen), 32'h0);
        step();
        chk("drop_then_m0", 32'(own_seen), 32'h1);

        // random traffic with periodic stall bursts
        drain();
        for (int i = 0; i < 3000; i++) begin
            knobs(40, 40, 3, (i % 400 < 40) ? 0 : 70, 5);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
